// File: rtl/tag_control.sv
// CAPI command tag allocator: hands out free tags from a FIFO, remembers the command
// line for each outstanding tag, and returns that line when the PSL response arrives.
package tag_control_pkg;

  localparam logic [7:0] CMD_READ  = 8'h0A;
  localparam logic [7:0] CMD_WRITE = 8'h0D;

  typedef struct packed {
    logic [7:0]  cu_id;
    logic [7:0]  cmd_type;
    logic [7:0]  tag;
    logic [31:0] address;
  } CommandTagLine;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic       tag_parity;
    logic [7:0] response;
    logic [8:0] credits;
  } ResponseInterface;

endpackage

module tag_control
  import tag_control_pkg::*;
#(
  parameter int TAG_COUNT = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             enabled_in,
  input  logic             tag_request,
  input  CommandTagLine    cmd_tag_line_in,
  input  ResponseInterface response,
  output logic             tag_ready,
  output logic             cmd_tag_valid_out,
  output CommandTagLine    cmd_tag_out,
  output CommandTagLine    response_tag_id_out,
  output logic [CNT_W-1:0] free_count_out,
  output logic [1:0]       tag_error
);

  localparam int TAG_W = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;

  localparam logic [1:0] DISABLED = 2'd0;
  localparam logic [1:0] INIT     = 2'd1;
  localparam logic [1:0] READY    = 2'd2;

  logic                 enabled;
  logic [1:0]           state;
  logic [TAG_W-1:0]     init_cnt;
  logic [TAG_W-1:0]     rd_ptr;
  logic [TAG_W-1:0]     wr_ptr;
  logic [TAG_COUNT-1:0] valid_bits;

  logic [TAG_W-1:0]     free_fifo [TAG_COUNT];
  CommandTagLine        tag_table [TAG_COUNT];

  logic [TAG_W-1:0]     resp_idx;
  logic [TAG_W-1:0]     head_tag;
  logic [TAG_W-1:0]     push_tag;
  logic                 resp_in_range;
  logic                 resp_hit;
  logic                 resp_miss;
  logic                 push;
  logic                 pop;
  CommandTagLine        grant_line;
  logic                 unused_bits;

  assign unused_bits = ^{response.tag_parity, response.response, response.credits,
                         cmd_tag_line_in.tag};

  assign tag_ready     = (state == READY) && (free_count_out != '0);
  assign head_tag      = free_fifo[rd_ptr];
  assign resp_idx      = response.tag[TAG_W-1:0];
  assign resp_in_range = int'(response.tag) < TAG_COUNT;

  // Responses only count once the tag pool is live; in INIT/DISABLED they are dropped.
  assign resp_hit  = enabled && (state == READY) && response.valid &&
                     resp_in_range && valid_bits[resp_idx];
  assign resp_miss = enabled && (state == READY) && response.valid &&
                     !(resp_in_range && valid_bits[resp_idx]);
  assign pop       = enabled && tag_request && tag_ready;
  assign push      = (enabled && (state == INIT)) || resp_hit;
  assign push_tag  = (state == INIT) ? init_cnt : resp_idx;

  always_comb begin
    grant_line     = cmd_tag_line_in;
    grant_line.tag = 8'(head_tag);
  end

  always_ff @(posedge clock) begin
    if (push) free_fifo[wr_ptr] <= push_tag;
    if (pop)  tag_table[head_tag] <= grant_line;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled             <= 1'b0;
      state               <= DISABLED;
      init_cnt            <= '0;
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      valid_bits          <= '0;
      free_count_out      <= '0;
      cmd_tag_valid_out   <= 1'b0;
      cmd_tag_out         <= '0;
      response_tag_id_out <= '0;
      tag_error           <= 2'b00;
    end else begin
      enabled             <= enabled_in;
      cmd_tag_valid_out   <= 1'b0;
      cmd_tag_out         <= '0;
      response_tag_id_out <= '0;

      // A single low cycle of the registered enable wipes the pool but keeps the error history.
      if (!enabled) begin
        state          <= DISABLED;
        init_cnt       <= '0;
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        valid_bits     <= '0;
        free_count_out <= '0;
      end else begin
        if (tag_request && !tag_ready && (state != DISABLED)) tag_error[1] <= 1'b1;
        if (resp_miss) tag_error[0] <= 1'b1;

        if (push) wr_ptr <= wr_ptr + TAG_W'(1);
        if (pop)  rd_ptr <= rd_ptr + TAG_W'(1);
        free_count_out <= free_count_out + CNT_W'(push) - CNT_W'(pop);

        if (pop) begin
          valid_bits[head_tag] <= 1'b1;
          cmd_tag_valid_out    <= 1'b1;
          cmd_tag_out          <= grant_line;
        end

        if (resp_hit) begin
          valid_bits[resp_idx] <= 1'b0;
          response_tag_id_out  <= tag_table[resp_idx];
        end

        case (state)
          DISABLED: begin
            state    <= INIT;
            init_cnt <= '0;
          end
          INIT: begin
            init_cnt <= init_cnt + TAG_W'(1);
            if (init_cnt == TAG_W'(TAG_COUNT - 1)) state <= READY;
          end
          READY:   state <= READY;
          default: state <= DISABLED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tag_control.sv
// Scoreboard bench for tag_control: a 256-tag instance and a 4-tag instance driven with
// directed vectors; grant and lookup expectations are queued and checked by a monitor.
module tb_tag_control;
  import tag_control_pkg::*;

  localparam int BIG_N = 256;
  localparam int BIG_W = 9;
  localparam int SM_N  = 4;
  localparam int SM_W  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstn;

  logic             b_en, b_req, b_ready, b_gv;
  CommandTagLine    b_cmd, b_gout, b_look;
  ResponseInterface b_resp;
  logic [BIG_W-1:0] b_cnt;
  logic [1:0]       b_err;

  logic             s_en, s_req, s_ready, s_gv;
  CommandTagLine    s_cmd, s_gout, s_look;
  ResponseInterface s_resp;
  logic [SM_W-1:0]  s_cnt;
  logic [1:0]       s_err;

  tag_control #(.TAG_COUNT(BIG_N), .CNT_W(BIG_W)) u_big (
    .clock(clock), .rstn(rstn), .enabled_in(b_en), .tag_request(b_req),
    .cmd_tag_line_in(b_cmd), .response(b_resp), .tag_ready(b_ready),
    .cmd_tag_valid_out(b_gv), .cmd_tag_out(b_gout), .response_tag_id_out(b_look),
    .free_count_out(b_cnt), .tag_error(b_err)
  );

  tag_control #(.TAG_COUNT(SM_N), .CNT_W(SM_W)) u_small (
    .clock(clock), .rstn(rstn), .enabled_in(s_en), .tag_request(s_req),
    .cmd_tag_line_in(s_cmd), .response(s_resp), .tag_ready(s_ready),
    .cmd_tag_valid_out(s_gv), .cmd_tag_out(s_gout), .response_tag_id_out(s_look),
    .free_count_out(s_cnt), .tag_error(s_err)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  CommandTagLine b_grant_q[$];
  CommandTagLine b_look_q[$];
  CommandTagLine s_grant_q[$];
  CommandTagLine s_look_q[$];

  CommandTagLine model_line [2][BIG_N];
  logic          model_alloc [2][BIG_N];

  logic          b_resp_seen = 1'b0;
  logic          s_resp_seen = 1'b0;
  CommandTagLine mon_exp;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: DUT produced output with no expectation queued", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One cycle of stimulus on the chosen instance; exp_tag < 0 means no grant is expected.
  task automatic applyStimulus(input bit sel_small, input bit req, input logic [7:0] cu,
                               input logic [7:0] ctype, input int exp_tag,
                               input bit rvalid, input int rtag);
    CommandTagLine line;
    CommandTagLine exp_look;
    line.cu_id    = cu;
    line.cmd_type = ctype;
    line.tag      = 8'hEE;
    line.address  = 32'h1000_0000 + 32'(cu) * 32'd64;
    if (rvalid) begin
      exp_look = '0;
      if (model_alloc[sel_small][rtag]) begin
        exp_look = model_line[sel_small][rtag];
        model_alloc[sel_small][rtag] = 1'b0;
      end
      if (sel_small) s_look_q.push_back(exp_look);
      else           b_look_q.push_back(exp_look);
    end
    if (req && exp_tag >= 0) begin
      model_line[sel_small][exp_tag]     = line;
      model_line[sel_small][exp_tag].tag = 8'(exp_tag);
      model_alloc[sel_small][exp_tag]    = 1'b1;
      if (sel_small) s_grant_q.push_back(model_line[1][exp_tag]);
      else           b_grant_q.push_back(model_line[0][exp_tag]);
    end
    if (sel_small) begin
      s_req = req; s_cmd = line; s_resp.valid = rvalid; s_resp.tag = 8'(rtag);
    end else begin
      b_req = req; b_cmd = line; b_resp.valid = rvalid; b_resp.tag = 8'(rtag);
    end
    tick();
    s_req = 1'b0; s_resp.valid = 1'b0;
    b_req = 1'b0; b_resp.valid = 1'b0;
  endtask

  always @(posedge clock) begin
    b_resp_seen <= b_resp.valid;
    s_resp_seen <= s_resp.valid;
  end

  // Monitor: pops one expectation whenever a DUT presents a grant or a lookup result.
  always @(negedge clock) begin
    if (b_gv) begin
      if (b_grant_q.size() == 0) reportUnexpected("big grant");
      else begin
        mon_exp = b_grant_q.pop_front();
        checkOutput("big grant line", 64'(b_gout), 64'(mon_exp));
      end
    end
    if (b_resp_seen) begin
      if (b_look_q.size() == 0) reportUnexpected("big lookup");
      else begin
        mon_exp = b_look_q.pop_front();
        checkOutput("big lookup line", 64'(b_look), 64'(mon_exp));
      end
    end
    if (s_gv) begin
      if (s_grant_q.size() == 0) reportUnexpected("small grant");
      else begin
        mon_exp = s_grant_q.pop_front();
        checkOutput("small grant line", 64'(s_gout), 64'(mon_exp));
      end
    end
    if (s_resp_seen) begin
      if (s_look_q.size() == 0) reportUnexpected("small lookup");
      else begin
        mon_exp = s_look_q.pop_front();
        checkOutput("small lookup line", 64'(s_look), 64'(mon_exp));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    b_en = 1'b0; b_req = 1'b0; b_cmd = '0; b_resp = '0;
    s_en = 1'b0; s_req = 1'b0; s_cmd = '0; s_resp = '0;
    for (int i = 0; i < BIG_N; i++) begin
      model_alloc[0][i] = 1'b0;
      model_alloc[1][i] = 1'b0;
    end

    #12;
    checkOutput("reset tag_ready", 64'(b_ready), 64'(0));
    checkOutput("reset free_count", 64'(b_cnt), 64'(0));
    checkOutput("reset grant valid", 64'(b_gv), 64'(0));
    checkOutput("reset lookup", 64'(b_look), 64'(0));
    checkOutput("reset tag_error", 64'(b_err), 64'(0));
    checkOutput("reset small free_count", 64'(s_cnt), 64'(0));
    #1 rstn = 1'b1;
    tick();

    // Big instance: INIT takes TAG_COUNT cycles after the DISABLED->INIT step.
    b_en = 1'b1;
    tick();
    repeat (256) tick();
    checkOutput("init not ready yet", 64'(b_ready), 64'(0));
    tick();
    checkOutput("init ready", 64'(b_ready), 64'(1));
    checkOutput("init free_count", 64'(b_cnt), 64'(256));

    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 8'(i), (i == 1) ? CMD_READ : CMD_WRITE, i, 0, 0);
    checkOutput("count after 4 grants", 64'(b_cnt), 64'(252));

    applyStimulus(0, 0, 8'h00, CMD_WRITE, -1, 1, 7);
    checkOutput("unallocated resp error", 64'(b_err), 64'(2'b01));
    checkOutput("unallocated resp count", 64'(b_cnt), 64'(252));

    applyStimulus(0, 0, 8'h00, CMD_WRITE, -1, 1, 1);
    checkOutput("free tag1 count", 64'(b_cnt), 64'(253));

    for (int t = 4; t <= 246; t++)
      applyStimulus(0, 1, 8'(t), CMD_WRITE, t, 0, 0);
    checkOutput("count at ten", 64'(b_cnt), 64'(10));
    applyStimulus(0, 1, 8'hA0, CMD_READ, 247, 1, 0);
    checkOutput("grant+free same cycle count", 64'(b_cnt), 64'(10));

    for (int t = 248; t <= 255; t++)
      applyStimulus(0, 1, 8'(t), CMD_WRITE, t, 0, 0);
    applyStimulus(0, 1, 8'hB1, CMD_WRITE, 1, 0, 0);
    applyStimulus(0, 1, 8'hB0, CMD_WRITE, 0, 0, 0);
    checkOutput("exhausted count", 64'(b_cnt), 64'(0));
    checkOutput("exhausted ready", 64'(b_ready), 64'(0));
    applyStimulus(0, 1, 8'hC0, CMD_WRITE, -1, 0, 0);
    checkOutput("request not ready error", 64'(b_err), 64'(2'b11));

    for (int t = 10; t <= 14; t++)
      applyStimulus(0, 0, 8'h00, CMD_WRITE, -1, 1, t);
    checkOutput("five free count", 64'(b_cnt), 64'(5));

    // Disable: the registered enable takes one edge, clearing takes the next.
    b_en = 1'b0;
    tick();
    checkOutput("disable registering count", 64'(b_cnt), 64'(5));
    tick();
    checkOutput("disabled count", 64'(b_cnt), 64'(0));
    checkOutput("disabled ready", 64'(b_ready), 64'(0));
    checkOutput("disabled error kept", 64'(b_err), 64'(2'b11));
    for (int i = 0; i < BIG_N; i++) model_alloc[0][i] = 1'b0;

    b_en = 1'b1;
    tick();
    repeat (256) tick();
    checkOutput("reinit not ready yet", 64'(b_ready), 64'(0));
    tick();
    checkOutput("reinit free_count", 64'(b_cnt), 64'(256));
    applyStimulus(0, 1, 8'h33, CMD_READ, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, CMD_WRITE, -1, 1, 12);
    applyStimulus(0, 0, 8'h00, CMD_WRITE, -1, 1, 0);
    checkOutput("reinit count after free", 64'(b_cnt), 64'(256));

    // Small instance: exhaust the pool, then a same-cycle request and free.
    s_en = 1'b1;
    tick();
    repeat (4) tick();
    checkOutput("small init not ready", 64'(s_ready), 64'(0));
    tick();
    checkOutput("small ready", 64'(s_ready), 64'(1));
    checkOutput("small free_count", 64'(s_cnt), 64'(4));
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 8'(8'h40 + i), CMD_WRITE, i, 0, 0);
    checkOutput("small exhausted ready", 64'(s_ready), 64'(0));
    checkOutput("small exhausted count", 64'(s_cnt), 64'(0));
    applyStimulus(1, 1, 8'h50, CMD_READ, -1, 1, 2);
    checkOutput("small not ready error", 64'(s_err), 64'(2'b10));
    checkOutput("small ready after free", 64'(s_ready), 64'(1));
    checkOutput("small count after free", 64'(s_cnt), 64'(1));
    applyStimulus(1, 1, 8'h51, CMD_READ, 2, 0, 0);
    checkOutput("small count after regrant", 64'(s_cnt), 64'(0));

    repeat (3) tick();
    checkOutput("big grants drained", 64'(b_grant_q.size()), 64'(0));
    checkOutput("big lookups drained", 64'(b_look_q.size()), 64'(0));
    checkOutput("small grants drained", 64'(s_grant_q.size()), 64'(0));
    checkOutput("small lookups drained", 64'(s_look_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/tag_control.md
Name: tag_control

Overview:
- Allocates CAPI command tags to the command path and records a CommandTagLine per outstanding tag.
- On each PSL response, looks up the stored line by response tag, returns it, and frees the tag.
- Sits directly upstream of response_control. Its response_tag_id_out drives response_control's response_tag_id_in, aligned with response_control's internally latched response.

Parameters:
- TAG_COUNT, 256: number of managed tags. Power of two, 2..256. Tags used are 0..TAG_COUNT-1.
- CNT_W, 9: width of the free counter. Must satisfy 2^CNT_W > TAG_COUNT.

Ports:
- clock  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- enabled_in  in  1  block enable, registered internally (1-cycle delay) as in the rest of the AFU.
- tag_request  in  1  command path requests a tag for cmd_tag_line_in.
- cmd_tag_line_in  in  CommandTagLine  command metadata (cu_id, cmd_type, address info); its tag field is ignored.
- response  in  ResponseInterface  raw PSL response (valid, tag, tag_parity, response, credits).
- tag_ready  out  1  a tag can be granted this cycle.
- cmd_tag_valid_out  out  1  grant strobe.
- cmd_tag_out  out  CommandTagLine  cmd_tag_line_in with its tag field set to the granted tag.
- response_tag_id_out  out  CommandTagLine  stored line for the responding tag.
- free_count_out  out  CNT_W  number of free tags.
- tag_error  out  2  sticky errors: bit0 = response to an unallocated tag; bit1 = request while not ready.

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs are 0.
  - Internal enabled, state, free FIFO pointers, free counter and table valid bits are cleared.
  - State is DISABLED.
- State machine (all transitions use the registered enabled):
  - DISABLED: when enabled is 1, go to INIT with init counter = 0.
  - INIT: push the init counter value into the free FIFO each cycle and increment. After tag TAG_COUNT-1 is pushed, go to READY. INIT therefore lasts exactly TAG_COUNT cycles, and free_count_out counts up to TAG_COUNT.
  - READY: normal operation.
  - From any state, enabled = 0 for one cycle returns to DISABLED. This clears all valid bits, FIFO pointers and the counter, and zeroes every output except tag_error.
- tag_ready = (state == READY) && (free count != 0). It is a combinational decode of registered state.
- Allocation:
  - A request is accepted in cycle N when tag_request && tag_ready.
  - The FIFO head tag t is popped, table[t] <= cmd_tag_line_in with tag = t, and valid[t] <= 1.
  - In cycle N+1, cmd_tag_valid_out = 1 and cmd_tag_out holds that line. Otherwise cmd_tag_valid_out = 0 and cmd_tag_out = 0.
  - Tags are granted in FIFO order. After INIT the order is 0, 1, 2, ...
- Request while not ready: no grant, no state change, tag_error[1] set. Requests in DISABLED are silently ignored.
- Response lookup: response.valid with tag t in cycle N (state READY):
  - If valid[t] = 1: in cycle N+1, response_tag_id_out = table[t] (tag field = t). valid[t] is cleared and t is pushed to the FIFO at the N+1 edge.
  - If valid[t] = 0: response_tag_id_out = 0, no push, tag_error[0] set.
  - When there is no response, response_tag_id_out = 0.
- Every valid response frees its tag regardless of response code. Replay and restart are handled elsewhere.
- Counter arithmetic: free count += push − pop, each 0/1.
  - Simultaneous grant and free leaves the count unchanged.
  - A tag freed in cycle N becomes grantable no earlier than cycle N+1. An empty FIFO never grants, even with a same-cycle free.
  - The FIFO cannot overflow: pushes only come from valid tags. Pointers wrap modulo TAG_COUNT.
- tag_error bits clear only on rstn.
- Responses arriving in INIT or DISABLED are dropped with no error.

Test Plan:
- Release reset, enabled_in = 1 -> tag_ready rises exactly TAG_COUNT+1 cycles after enable registers (257 for default) with free_count_out = 256. Four back-to-back requests -> grants with tags 0, 1, 2, 3 on consecutive cycles; count = 252.
- Allocate tag 1 with cmd_type CMD_READ, then response.valid with tag = 1 -> next cycle response_tag_id_out.cmd_type = CMD_READ, tag = 1; count increments by 1. Tag 1 is re-granted only after tags 4..255 are consumed.
- TAG_COUNT = 4: allocate all 4 -> tag_ready = 0 and count = 0. Request plus response for tag 2 in the same cycle -> no grant that cycle, tag_error[1] set. Next cycle tag_ready = 1 and a request is granted tag 2.
- Count = 10, request and valid response in the same cycle -> one grant, one lookup, free_count_out stays 10.
- Response to tag 7 never allocated -> response_tag_id_out = 0, tag_error = 2'b01 held until reset, count unchanged.
- Disable mid-operation with 5 tags outstanding -> outputs and counter go to 0 one cycle after enable deassertion registers. Re-enable -> full INIT rerun, grants restart at tag 0.
